clint_apb_arbiter: RTL
======================

Name: clint_apb_arbiter

Overview:
- Shares the single APB slave port of the core-local interrupter (mtime/mtimecmp/msip) among NUM_REQ requesters, e.g. hart LSU, debug module, and a timer-management DMA.
- Each requester uses a simple req/rsp handshake. The block sequences APB SETUP/ACCESS phases, arbitrates round-robin, and returns read data and error per requester.
- Sits between the requesters and the interrupter's APB port, in the core complex.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- APB_ADDR_WIDTH, 12, APB address width.
- TIMEOUT_CYCLES, 64, ACCESS-phase wait limit; used only with the optional feature.

Ports:
- PCLK  input  1  clock.
- PRESETn  input  1  reset, asynchronous, active-low.
- req_i  input  NUM_REQ  per-requester transfer request; held until rsp_vld_o.
- we_i  input  NUM_REQ  per-requester write enable.
- addr_i  input  NUM_REQ*APB_ADDR_WIDTH  per-requester address, packed, requester 0 in LSBs.
- wdata_i  input  NUM_REQ*32  per-requester write data, packed.
- rsp_vld_o  output  NUM_REQ  one-cycle completion pulse to the owner.
- rsp_err_o  output  1  error flag, valid with rsp_vld_o.
- rsp_rdata_o  output  32  read data, valid with rsp_vld_o; 0 for writes.
- PADDR  output  APB_ADDR_WIDTH  APB address.
- PWDATA  output  32  APB write data.
- PWRITE  output  1  APB write.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PRDATA  input  32  APB read data.
- PREADY  input  1  APB ready.
- PSLVERR  input  1  APB error.

Behaviour:
- Reset values: FSM=IDLE; rr pointer=0 (requester 0 highest priority); all APB outputs 0; rsp_vld_o=0, rsp_err_o=0, rsp_rdata_o=0; owner=0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any req_i is set, pick the winner round-robin, searching from index (last_owner+1) mod NUM_REQ upward with wrap.
  - Register owner, addr, wdata and we of the winner, then go to SETUP.
  - If no req_i is set, stay in IDLE.
- SETUP: PSEL=1, PENABLE=0, PADDR/PWDATA/PWRITE from the registered copy. Unconditionally go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - PREADY=0: stay in ACCESS, outputs stable.
  - PREADY=1: capture PRDATA (reads only; writes capture 0) and PSLVERR, update last_owner=owner, go to RESP.
- RESP:
  - rsp_vld_o[owner]=1 for exactly one cycle, with rsp_rdata_o/rsp_err_o; PSEL=PENABLE=0.
  - Always return to IDLE; there is no back-to-back SETUP.
  - The requester drops or changes req_i on the edge after seeing rsp_vld_o. The IDLE-cycle arbitration therefore never re-issues the same transfer.
- Latency: the request is seen in IDLE at cycle N. SETUP is N+1, ACCESS is N+2, and rsp_vld_o is at N+3 with zero wait states. Each PREADY=0 cycle adds one cycle. Minimum period is 4 cycles per transfer.
- Outside RESP, rsp_rdata_o/rsp_err_o hold their last value; rsp_vld_o=0.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers stay pending with no starvation, bounded by NUM_REQ transfers.
- A requester deasserting req_i before rsp_vld_o is illegal once granted. The transfer completes and the response is still pulsed.
- Reset asserted mid-transfer: everything returns to reset values immediately, PSEL drops asynchronously, and the in-flight response is lost.
- Addresses are passed unmodified. Decode and unmapped-address handling belong to the slave.

Optional Feature:
- Macro CLINT_ARB_TIMEOUT_EN.
- Defined:
  - A wait counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the counter reaches TIMEOUT_CYCLES, force the transfer to RESP with rsp_err_o=1 and rsp_rdata_o=0, and drop PSEL/PENABLE.
  - A sticky status bit timeout_o (extra 1-bit output, reset 0) sets and stays set until reset.
- Undefined: no counter and no timeout_o port; ACCESS waits on PREADY indefinitely.

Decomposition:
- Package clint_arb_pkg: FSM state enum {IDLE, SETUP, ACCESS, RESP} and the RSP_ERR_DATA constant (32'h0).
- Sub-module rr_arbiter (parameter NUM_REQ): combinational inputs req vector and last_owner; outputs a one-hot grant and an index.

Test Plan:
- Single write: req_i=3'b001, we=1, addr=12'h004, wdata=32'h100, PREADY=1 → SETUP at N+1, ACCESS at N+2, rsp_vld_o=3'b001 at N+3, rsp_rdata_o=0, rsp_err_o=0.
- Single read with 3 wait states: requester 1 reads 12'h000, slave returns PRDATA=32'h55 after 3 PREADY=0 cycles → PADDR/PSEL stable throughout; rsp_vld_o=3'b010 at N+6 with rsp_rdata_o=32'h55.
- Contention: all three requesters hold req from reset → grant order 0,1,2,0; each rsp_vld_o is one-hot; PSEL drops for ≥2 cycles (RESP, IDLE) between transfers.
- Error propagation: PSLVERR=1 with PREADY=1 on a write to 12'h008 → rsp_err_o=1 alongside rsp_vld_o.
- Reset mid-ACCESS: PRESETn low while PREADY=0 → PSEL=PENABLE=0 asynchronously, no rsp_vld_o, next grant goes to requester 0.
- CLINT_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4 and PREADY held 0 → after 4 wait cycles, rsp_vld_o pulses with rsp_err_o=1, rsp_rdata_o=0 and timeout_o=1 (stays 1).

Source files
------------

// File: rtl/clint_apb_arbiter_pkg.sv
// Shared types and constants for the CLINT APB arbiter.
// Contents: transfer FSM state encoding, read-data value returned on
// writes and on forced (timed-out) completions.
package clint_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    localparam logic [31:0] RSP_ERR_DATA = 32'h0;

endpackage

// File: rtl/clint_apb_arbiter_if.sv
// APB3 bus bundle between the arbiter (master) and the interrupter (slave).
// Signals: PADDR/PWDATA/PWRITE/PSEL/PENABLE driven by the master;
// PRDATA/PREADY/PSLVERR returned by the slave.
interface clint_apb_arbiter_if #(
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [31:0]           PWDATA;
    logic                  PWRITE;
    logic                  PSEL;
    logic                  PENABLE;
    logic [31:0]           PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/clint_apb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches from last_owner_i+1 upward with wrap.
// Ports: req_i request vector, last_owner_i previous winner index,
// gnt_o one-hot grant (all-zero when no request), idx_o winner index.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    localparam int IDXW   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDXW-1:0]    last_owner_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDXW-1:0]    idx_o
);
    int unsigned cand;
    logic        found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(last_owner_i) + 1 + i) % NUM_REQ;
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IDXW'(cand);
            end
        end
    end
endmodule

// File: rtl/clint_apb_arbiter.sv
// Round-robin sharing of the CLINT APB slave port among NUM_REQ req/rsp requesters.
// Latency: request seen in IDLE at N -> SETUP N+1, ACCESS N+2, rsp_vld_o N+3 (+1 per PREADY=0 cycle).
// Backpressure: requesters hold req_i until their rsp_vld_o pulse; slave stalls ACCESS via PREADY.
// Ports: PCLK/PRESETn, per-requester req/we/addr/wdata (packed, requester 0 in LSBs),
// rsp_vld_o/rsp_err_o/rsp_rdata_o, APB master modport.
// Optional: CLINT_ARB_TIMEOUT_EN adds an ACCESS wait limit and the sticky timeout_o output.
module clint_apb_arbiter
    import clint_arb_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int APB_ADDR_WIDTH = 12
`ifdef CLINT_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            we_i,
    input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_REQ*32-1:0]         wdata_i,
    output logic [NUM_REQ-1:0]            rsp_vld_o,
    output logic                          rsp_err_o,
    output logic [31:0]                   rsp_rdata_o,
`ifdef CLINT_ARB_TIMEOUT_EN
    output logic                          timeout_o,
`endif
    clint_apb_arbiter_if.master           apb
);
    localparam int IDXW = $clog2(NUM_REQ);

    arb_state_t                state_q;
    logic [IDXW-1:0]           owner_q;
    logic [NUM_REQ-1:0]        owner_oh_q;
    logic [IDXW-1:0]           last_owner_q;
    logic [APB_ADDR_WIDTH-1:0] paddr_q;
    logic [31:0]               pwdata_q;
    logic                      pwrite_q;
    logic                      psel_q;
    logic                      penable_q;
    logic [NUM_REQ-1:0]        rsp_vld_q;
    logic                      rsp_err_q;
    logic [31:0]               rsp_rdata_q;

    logic [NUM_REQ-1:0]        gnt;
    logic [IDXW-1:0]           gnt_idx;

`ifdef CLINT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q;
    logic             timeout_q;
    assign timeout_o = timeout_q;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i        (req_i),
        .last_owner_i (last_owner_q),
        .gnt_o        (gnt),
        .idx_o        (gnt_idx)
    );

    // last_owner resets to the top index so the first search starts at
    // requester 0, i.e. requester 0 has highest priority out of reset.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            owner_oh_q   <= '0;
            last_owner_q <= IDXW'(NUM_REQ - 1);
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pwrite_q     <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            rsp_vld_q    <= '0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
`ifdef CLINT_ARB_TIMEOUT_EN
            wait_cnt_q   <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            rsp_vld_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|req_i) begin
                        owner_q    <= gnt_idx;
                        owner_oh_q <= gnt;
                        paddr_q    <= addr_i[gnt_idx*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
                        pwdata_q   <= wdata_i[gnt_idx*32 +: 32];
                        pwrite_q   <= we_i[gnt_idx];
                        psel_q     <= 1'b1;
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
`ifdef CLINT_ARB_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                end
                ACCESS: begin
                    if (apb.PREADY) begin
                        psel_q       <= 1'b0;
                        penable_q    <= 1'b0;
                        rsp_vld_q    <= owner_oh_q;
                        rsp_err_q    <= apb.PSLVERR;
                        rsp_rdata_q  <= pwrite_q ? 32'h0 : apb.PRDATA;
                        last_owner_q <= owner_q;
                        state_q      <= RESP;
                    end
`ifdef CLINT_ARB_TIMEOUT_EN
                    // This stalled cycle brings the count to TIMEOUT_CYCLES:
                    // abandon the transfer and answer with an error.
                    else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        psel_q       <= 1'b0;
                        penable_q    <= 1'b0;
                        rsp_vld_q    <= owner_oh_q;
                        rsp_err_q    <= 1'b1;
                        rsp_rdata_q  <= RSP_ERR_DATA;
                        last_owner_q <= owner_q;
                        timeout_q    <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
`endif
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PSEL    = psel_q;
    assign apb.PENABLE = penable_q;

    assign rsp_vld_o   = rsp_vld_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;
endmodule
